// File: rtl/query_row_buffer_ctrl_pkg.sv
// Shared types and helpers for the query-row double-buffer controller.
package query_row_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_t;

    localparam int unsigned ADDR_WIDTH_DEF = 7;
    localparam int unsigned WORD_IDX_W     = ADDR_WIDTH_DEF - 1;

    function automatic int unsigned word_idx_w(input int unsigned addr_width);
        return addr_width - 1;
    endfunction

endpackage

// File: rtl/ren_latency_pipe.sv
// DEPTH-deep valid shift register with synchronous clear; tracks buffer read latency.
module ren_latency_pipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/query_row_buffer_ctrl.sv
// Query-row double-buffer sequencer: bank ping-pong, write/read counters,
// write back-pressure, row read issue and read-latency tracking.
module query_row_buffer_ctrl
    import query_row_buffer_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned ROW_LEN    = 64,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fsm_enable,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  buf_wen,
    output logic [ADDR_WIDTH-1:0] buf_wadr,
    input  logic                  rd_start,
    input  logic                  rd_stall,
    output logic                  buf_ren,
    output logic [ADDR_WIDTH-1:0] buf_radr,
    output logic                  rd_data_valid,
    output logic                  row_avail,
    output logic                  row_done,
    output logic [1:0]            full_banks
);

    localparam int unsigned    WIW        = word_idx_w(ADDR_WIDTH);
    localparam logic [WIW-1:0] LAST_IDX   = WIW'(ROW_LEN - 1);
    localparam logic [1:0]     DRAIN_LAST = 2'(RD_LATENCY - 1);

    logic           wbank;
    logic           rbank;
    logic [WIW-1:0] wcnt;
    logic [WIW-1:0] rcnt;
    logic [1:0]     bank_full;
    logic [1:0]     drain_cnt;
    logic [1:0]     set_mask;
    logic [1:0]     clr_mask;
    rd_state_t      state;

    assign wr_ready   = fsm_enable & ~flush & ~bank_full[wbank];
    assign buf_wen    = wr_valid & wr_ready;
    assign buf_wadr   = {wbank, wcnt};
    assign buf_ren    = (state == ISSUE) & ~rd_stall;
    assign buf_radr   = {rbank, rcnt};
    assign row_avail  = bank_full[rbank] & (state == IDLE);
    assign row_done   = (state == DRAIN) & (drain_cnt == DRAIN_LAST);
    assign full_banks = 2'(bank_full[0]) + 2'(bank_full[1]);

    // Set and release always hit different banks, so both masks apply together.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (buf_wen && (wcnt == LAST_IDX)) begin
            set_mask[wbank] = 1'b1;
        end
        if (row_done) begin
            clr_mask[rbank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank     <= 1'b0;
            wcnt      <= '0;
            bank_full <= '0;
        end else if (flush) begin
            wbank     <= 1'b0;
            wcnt      <= '0;
            bank_full <= '0;
        end else begin
            if (buf_wen) begin
                if (wcnt == LAST_IDX) begin
                    wcnt  <= '0;
                    wbank <= ~wbank;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            bank_full <= (bank_full | set_mask) & ~clr_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rbank     <= 1'b0;
            rcnt      <= '0;
            drain_cnt <= '0;
        end else if (flush) begin
            state     <= IDLE;
            rbank     <= 1'b0;
            rcnt      <= '0;
            drain_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_start && row_avail && fsm_enable) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!rd_stall) begin
                        if (rcnt == LAST_IDX) begin
                            rcnt      <= '0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // row_done lines up with the last word leaving the latency pipe
                    if (row_done) begin
                        rbank     <= ~rbank;
                        drain_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ren_latency_pipe #(
        .DEPTH(RD_LATENCY)
    ) u_ren_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (flush),
        .din  (buf_ren),
        .dout (rd_data_valid)
    );

endmodule

// File: tb/tb_query_row_buffer_ctrl.sv
// Scoreboard bench for query_row_buffer_ctrl (ADDR_WIDTH=7, ROW_LEN=64, RD_LATENCY=2).
module tb_query_row_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fsm_enable;
    logic       flush;
    logic       wr_valid;
    logic       wr_ready;
    logic       buf_wen;
    logic [6:0] buf_wadr;
    logic       rd_start;
    logic       rd_stall;
    logic       buf_ren;
    logic [6:0] buf_radr;
    logic       rd_data_valid;
    logic       row_avail;
    logic       row_done;
    logic [1:0] full_banks;

    query_row_buffer_ctrl #(
        .ADDR_WIDTH(7),
        .ROW_LEN   (64),
        .RD_LATENCY(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fsm_enable   (fsm_enable),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .buf_wen      (buf_wen),
        .buf_wadr     (buf_wadr),
        .rd_start     (rd_start),
        .rd_stall     (rd_stall),
        .buf_ren      (buf_ren),
        .buf_radr     (buf_radr),
        .rd_data_valid(rd_data_valid),
        .row_avail    (row_avail),
        .row_done     (row_done),
        .full_banks   (full_banks)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int wq[$];
    int rq[$];
    int cyc = 0;
    int first_ren = 0;
    int in_row = 0;
    int vrow = 0;
    int vtot = 0;
    int rows_done = 0;
    int row_cycles = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops expected addresses whenever the DUT strobes, tracks valid pulses.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (buf_wen) begin
                if (wq.size() == 0) chk("wen_unexpected", int'(buf_wen), 0);
                else chk("wadr", int'(buf_wadr), wq.pop_front());
            end
            if (buf_ren) begin
                if (in_row == 0) begin
                    in_row    = 1;
                    first_ren = cyc;
                end
                if (rq.size() == 0) chk("ren_unexpected", int'(buf_ren), 0);
                else chk("radr", int'(buf_radr), rq.pop_front());
            end
            if (rd_data_valid) begin
                vtot++;
                if (vrow == 0) chk("first_valid_latency", cyc - first_ren, 2);
                vrow++;
            end
            if (row_done) begin
                chk("done_with_last_valid", int'(rd_data_valid), 1);
                chk("valid_count", vrow, 64);
                row_cycles = cyc - first_ren;
                rows_done++;
                vrow   = 0;
                in_row = 0;
            end
            if (flush) begin
                vrow   = 0;
                in_row = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_n(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wq.push_back(base + i);
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input int base, input bit stall3, input int exp_cycles);
        int start;
        int j;
        for (int i = 0; i < 64; i++) rq.push_back(base + i);
        start    = rows_done;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        j = 0;
        while (rows_done == start && j < 300) begin
            rd_stall = stall3 && (j % 3 == 2);
            step();
            j++;
        end
        rd_stall = 1'b0;
        if (rows_done == start) chk("row_done_timeout", rows_done - start, 1);
        else chk("row_done_cycles", row_cycles, exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wen_seen;
        int vsnap;
        rst_n = 1'b0; fsm_enable = 1'b0; flush = 1'b0;
        wr_valid = 1'b0; rd_start = 1'b0; rd_stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wr_ready", int'(wr_ready), 0);
        chk("rst_ren_valid_done", int'({buf_ren, rd_data_valid, row_done, row_avail}), 0);
        chk("rst_full_banks", int'(full_banks), 0);
        chk("rst_addrs", int'({buf_wadr, buf_radr}), 0);
        step();
        rst_n = 1'b1;
        fsm_enable = 1'b1;
        step();
        chk("en_wr_ready", int'(wr_ready), 1);

        // first bank fill, then one more word into bank 1
        write_n(0, 64);
        chk("fill0_full_banks", int'(full_banks), 1);
        chk("fill0_next_wadr", int'(buf_wadr), 64);
        chk("fill0_row_avail", int'(row_avail), 1);
        write_n(64, 1);
        write_n(65, 63);
        chk("fill2_full_banks", int'(full_banks), 2);
        chk("fill2_wr_ready", int'(wr_ready), 0);

        // back-pressure: wr_valid held with both banks full
        wen_seen = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (buf_wen) wen_seen++;
            step();
        end
        wr_valid = 1'b0;
        chk("bp_no_wen", wen_seen, 0);

        // plain read of bank 0
        do_read(0, 1'b0, 65);
        chk("rd0_full_banks", int'(full_banks), 1);
        chk("rd0_wr_ready", int'(wr_ready), 1);

        // stalled read of bank 1: 31 stall cycles inside the issue window
        do_read(64, 1'b1, 96);
        chk("rd1_full_banks", int'(full_banks), 0);
        chk("empty_row_avail", int'(row_avail), 0);

        // refill bank 0 with fsm_enable dropped mid-row
        write_n(0, 32);
        fsm_enable = 1'b0;
        wr_valid = 1'b1;
        repeat (3) step();
        chk("dis_wr_ready", int'(wr_ready), 0);
        fsm_enable = 1'b1;
        wr_valid = 1'b0;
        write_n(32, 32);
        chk("refill_full_banks", int'(full_banks), 1);

        // concurrent: read bank 0 while writing bank 1, release and set coincide
        for (int i = 0; i < 64; i++) rq.push_back(i);
        for (int k = 0; k < 70; k++) begin
            rd_start = (k == 0);
            wr_valid = (k >= 3 && k < 67);
            if (wr_valid) wq.push_back(64 + k - 3);
            @(negedge clk);
            if (k == 66) begin
                chk("conc_row_done", int'(row_done), 1);
                chk("conc_wen", int'(buf_wen), 1);
            end
            step();
        end
        rd_start = 1'b0;
        wr_valid = 1'b0;
        chk("conc_full_banks", int'(full_banks), 1);
        do_read(64, 1'b0, 65);
        chk("conc_rd1_full_banks", int'(full_banks), 0);

        // flush while issuing word 30
        write_n(0, 64);
        for (int i = 0; i <= 30; i++) rq.push_back(i);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        for (int j = 0; j < 30; j++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_ren_valid_done", int'({buf_ren, rd_data_valid, row_done, row_avail}), 0);
        chk("flush_full_banks", int'(full_banks), 0);
        chk("flush_addrs", int'({buf_wadr, buf_radr}), 0);
        vsnap = vtot;
        repeat (10) step();
        chk("flush_no_valid", vtot - vsnap, 0);
        write_n(0, 1);
        step();

        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
